// File: rtl/spi_target_wb.sv
// spi_target_wb: SPI mode-0 target driving a Wishbone initiator.
// Flash-style cmd/addr/data stream; one bus cycle per 32-bit word.
module spi_target_wb #(
  parameter logic [7:0]  BASE_HI = 8'h30,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sclk_i,
  input  logic        csb_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY,
    S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  sclk_sy;
  logic [1:0]  csb_sy, mosi_sy;
  logic        rise_q, fall_q;
  logic        csb_s, mosi_s;
  logic [4:0]  bitcnt;
  logic [30:0] rx;
  logic [31:0] rx_n, tx, rbuf;
  logic [23:0] addr;
  logic        cmd_wr, rvalid, drop;
  logic        ev_rd, ev_wr, ev_load, ev_any, ld_err;
  logic [21:0] ev_adr;
  logic        cyc, we;
  logic [15:0] tcnt;
  logic        tmo, bus_end;
  logic        pend, pend_we;
  logic [21:0] pend_adr;
  logic [31:0] pend_dat;
  logic        st_we;
  logic [21:0] st_adr;
  logic [31:0] st_dat;

  assign csb_s  = csb_sy[1];
  assign mosi_s = mosi_sy[1];
  assign rx_n   = {rx, mosi_s};

  // 2-FF synchronisers plus registered sclk edge strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sy <= '0;
      csb_sy  <= 2'b11;
      mosi_sy <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[1:0], sclk_i};
      csb_sy  <= {csb_sy[0], csb_i};
      mosi_sy <= {mosi_sy[0], mosi_i};
      rise_q  <= sclk_sy[1] & ~sclk_sy[2];
      fall_q  <= ~sclk_sy[1] & sclk_sy[2];
    end
  end

  // Protocol state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state and bus request events
  always_comb begin
    state_n = state;
    ev_rd   = 1'b0;
    ev_wr   = 1'b0;
    ev_load = 1'b0;
    ev_adr  = addr[23:2];
    if (csb_s) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: state_n = S_CMD;
        S_CMD: begin
          if (rise_q && bitcnt == 5'd7) begin
            unique case (1'b1)
              rx_n[7:0] == 8'h02: state_n = S_ADDR;
              rx_n[7:0] == 8'h03: state_n = S_ADDR;
              default:            state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (rise_q && bitcnt == 5'd23) begin
            if (cmd_wr) begin
              state_n = S_WDATA;
            end else begin
              state_n = S_DUMMY;
              ev_rd   = 1'b1;
              ev_adr  = rx_n[23:2];
            end
          end
        end
        S_DUMMY: begin
          if (rise_q && bitcnt == 5'd7) state_n = S_RDATA;
        end
        S_RDATA: begin
          if (fall_q && bitcnt == 5'd0) begin
            ev_load = 1'b1;
            ev_rd   = 1'b1;
            ev_adr  = addr[23:2] + 22'd1;
          end
        end
        S_WDATA: begin
          if (rise_q && bitcnt == 5'd31) ev_wr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ev_any = ev_rd | ev_wr;
  assign ld_err = ev_load & ~rvalid;

  // Shift registers, bit counter and running address
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx     <= '0;
      tx     <= '0;
      bitcnt <= '0;
      addr   <= '0;
      cmd_wr <= 1'b0;
    end else begin
      if (rise_q) rx <= rx_n[30:0];
      if (csb_s || state_n != state) bitcnt <= '0;
      else if (rise_q)               bitcnt <= bitcnt + 5'd1;
      if (state == S_CMD && rise_q && bitcnt == 5'd7)
        cmd_wr <= (rx_n[7:0] == 8'h02);
      if (!csb_s && state == S_ADDR && rise_q && bitcnt == 5'd23)
        addr <= rx_n[23:0];
      else if (ev_wr || ev_load)
        addr <= addr + 24'd4;
      if (ev_load)
        tx <= rvalid ? rbuf : 32'hFFFF_FFFF;
      else if (state == S_RDATA && fall_q)
        tx <= {tx[30:0], 1'b1};
    end
  end

  assign tmo     = (tcnt == 16'(TIMEOUT - 1));
  assign bus_end = cyc & (ack_i | tmo);
  assign st_we   = ev_any ? ev_wr  : pend_we;
  assign st_adr  = ev_any ? ev_adr : pend_adr;
  assign st_dat  = ev_any ? rx_n   : pend_dat;

  // Wishbone initiator: one request in flight, one deferred
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc      <= 1'b0;
      we       <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      tcnt     <= '0;
      rbuf     <= '0;
      rvalid   <= 1'b0;
      drop     <= 1'b0;
      pend     <= 1'b0;
      pend_we  <= 1'b0;
      pend_adr <= '0;
      pend_dat <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= ld_err;
      if (cyc) begin
        if (bus_end) begin
          cyc  <= 1'b0;
          we   <= 1'b0;
          drop <= 1'b0;
          if (!we && !drop) begin
            rbuf   <= ack_i ? dat_i : 32'hFFFF_FFFF;
            rvalid <= 1'b1;
          end
          if (!ack_i) err_o <= 1'b1;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        if (ev_any) begin
          pend     <= 1'b1;
          pend_we  <= ev_wr;
          pend_adr <= ev_adr;
          pend_dat <= rx_n;
        end
      end else if (ev_any || pend) begin
        cyc   <= 1'b1;
        tcnt  <= '0;
        pend  <= 1'b0;
        we    <= st_we;
        adr_o <= {BASE_HI, st_adr, 2'b00};
        if (st_we) dat_o  <= st_dat;
        else       rvalid <= 1'b0;
      end
      if (ev_load) begin
        rvalid <= 1'b0;
        if (cyc && !we && !bus_end) drop <= 1'b1;
      end
    end
  end

  assign cyc_o     = cyc;
  assign stb_o     = cyc;
  assign we_o      = we;
  assign sel_o     = {4{cyc}};
  assign busy_o    = ~csb_s | cyc;
  assign miso_oe_o = (state == S_RDATA) & ~csb_s;
  assign miso_o    = miso_oe_o & tx[31];

endmodule

// File: tb/tb_spi_target_wb.sv
// tb_spi_target_wb: randomized SPI host plus Wishbone target model
// checking spi_target_wb against word-level expectations.
module tb_spi_target_wb;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        csb = 1'b1;
  logic        mosi = 1'b0;
  logic        miso_o, miso_oe_o;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        busy_o, err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } cyc_t;

  cyc_t        log_q[$];
  int          len_q[$];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] preset [logic [23:0]];
  int          ack_delay = 2;
  bit          ack_en = 1'b1;
  int          err_pulses = 0;
  bit          oe_seen = 1'b0;

  always #5 clk = ~clk;

  spi_target_wb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sclk_i(sclk), .csb_i(csb), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    if (preset.exists(a)) return preset[a];
    return {a[7:0] ^ 8'hC3, a};
  endfunction

  // Wishbone target: logs cycles, acks after ack_delay clocks
  initial begin : responder
    bit active;
    int cnt;
    cyc_t e;
    active = 1'b0;
    cnt = 0;
    ack_i = 1'b0;
    dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      ack_i = 1'b0;
      if (err_o) err_pulses++;
      if (miso_oe_o) oe_seen = 1'b1;
      if (!cyc_o) begin
        if (active) len_q.push_back(cnt);
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          e.adr = adr_o;
          e.dat = dat_o;
          e.we  = we_o;
          e.sel = sel_o;
          log_q.push_back(e);
        end
        cnt++;
        if (ack_en && cnt == ack_delay) begin
          ack_i = 1'b1;
          dat_i = we_o ? 32'h0 : mem_rd(adr_o[23:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] o, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = o[i];
      tick(HALF);
      sclk = 1'b1;
      r[i] = miso_o;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_start();
    csb = 1'b0;
    tick(8);
  endtask

  task automatic spi_stop();
    tick(10);
    csb = 1'b1;
    tick(10);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    spi_byte(cmd, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
  endtask

  task automatic clear_log();
    log_q.delete();
    len_q.delete();
    err_pulses = 0;
    oe_seen = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((cyc_o || busy_o) && n < 400) begin
      tick(1);
      n++;
    end
    tick(2);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s idle: bus still busy after %0d clk", tag, n);
    end
  endtask

  task automatic do_write(input logic [23:0] a, input int extra);
    logic [7:0] r;
    clear_log();
    spi_start();
    send_hdr(8'h02, a);
    foreach (wq[i]) begin
      for (int b = 3; b >= 0; b--) spi_byte(wq[i][8*b +: 8], r);
    end
    for (int k = 0; k < extra; k++) spi_byte(8'($urandom), r);
    spi_stop();
    wait_idle("write");
  endtask

  task automatic check_writes(input string tag, input logic [23:0] a);
    checks++;
    if (log_q.size() != wq.size()) begin
      errors++;
      $display("FAIL %s count: got %0d cycles expected %0d",
               tag, log_q.size(), wq.size());
    end
    foreach (wq[i]) begin
      logic [23:0] ea;
      ea = (a & 24'hFFFFFC) + 24'(4 * i);
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i].adr !== {8'h30, ea} || log_q[i].dat !== wq[i] ||
            log_q[i].we !== 1'b1 || log_q[i].sel !== 4'hF) begin
          errors++;
          $display("FAIL %s word%0d: got adr=%h dat=%h we=%b sel=%h expected adr=%h dat=%h we=1 sel=f",
                   tag, i, log_q[i].adr, log_q[i].dat, log_q[i].we,
                   log_q[i].sel, {8'h30, ea}, wq[i]);
        end
      end
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int nw);
    logic [7:0] r;
    logic [31:0] w;
    clear_log();
    rq.delete();
    spi_start();
    send_hdr(8'h03, a);
    spi_byte(8'($urandom), r);
    for (int i = 0; i < nw; i++) begin
      for (int b = 3; b >= 0; b--) begin
        spi_byte(8'($urandom), r);
        w[8*b +: 8] = r;
      end
      rq.push_back(w);
    end
    spi_stop();
    wait_idle("read");
  endtask

  // A read of nw words loads nw+1 words (the last on the final fall),
  // so the bus sees the initial read plus nw+1 prefetches.
  task automatic check_reads(input string tag, input logic [23:0] a,
                             input int nw, input bit tmo);
    logic [31:0] exp;
    for (int k = 0; k < nw; k++) begin
      exp = tmo ? 32'hFFFF_FFFF : mem_rd((a & 24'hFFFFFC) + 24'(4 * k));
      checks++;
      if (rq[k] !== exp) begin
        errors++;
        $display("FAIL %s miso word%0d: got %h expected %h", tag, k, rq[k], exp);
      end
    end
    checks++;
    if (log_q.size() != nw + 2) begin
      errors++;
      $display("FAIL %s read count: got %0d expected %0d", tag, log_q.size(), nw + 2);
    end
    foreach (log_q[i]) begin
      logic [23:0] ea;
      ea = (a & 24'hFFFFFC) + 24'(4 * i);
      checks++;
      if (log_q[i].adr !== {8'h30, ea} || log_q[i].we !== 1'b0 ||
          log_q[i].sel !== 4'hF) begin
        errors++;
        $display("FAIL %s read%0d: got adr=%h we=%b sel=%h expected adr=%h we=0 sel=f",
                 tag, i, log_q[i].adr, log_q[i].we, log_q[i].sel, {8'h30, ea});
      end
    end
    checks++;
    if (oe_seen !== 1'b1 || miso_oe_o !== 1'b0) begin
      errors++;
      $display("FAIL %s miso_oe: got seen=%b after=%b expected seen=1 after=0",
               tag, oe_seen, miso_oe_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(4);
    checks++;
    if ({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
         miso_o, miso_oe_o, busy_o, err_o} !== 75'd0) begin
      errors++;
      $display("FAIL reset outputs: got cyc=%b adr=%h dat=%h busy=%b oe=%b expected all 0",
               cyc_o, adr_o, dat_o, busy_o, miso_oe_o);
    end
    rst_n = 1'b1;
    tick(4);
    checks++;
    if ({cyc_o, busy_o, err_o, miso_oe_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset release: got cyc=%b busy=%b err=%b oe=%b expected 0",
               cyc_o, busy_o, err_o, miso_oe_o);
    end
  endtask

  task automatic test_single_write();
    wq.delete();
    wq.push_back(32'hA5A5_1234);
    do_write(24'h000010, 0);
    check_writes("single_write", 24'h000010);
  endtask

  task automatic test_burst_wrap();
    wq.delete();
    wq.push_back($urandom);
    wq.push_back($urandom);
    do_write(24'hFFFFFC, 0);
    check_writes("burst_wrap", 24'hFFFFFC);
  endtask

  task automatic test_random_writes();
    for (int t = 0; t < 3; t++) begin
      logic [23:0] a;
      a = 24'($urandom);
      wq.delete();
      for (int i = 0; i < $urandom_range(1, 3); i++) wq.push_back($urandom);
      do_write(a, $urandom_range(0, 3));
      check_writes("random_write", a);
    end
  endtask

  task automatic test_read_prefetch();
    preset[24'h000020] = 32'hDEAD_BEEF;
    ack_delay = 2;
    do_read(24'h000020, 1);
    check_reads("read_prefetch", 24'h000020, 1, 1'b0);
    checks++;
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL read_prefetch err: got %0d pulses expected 0", err_pulses);
    end
  endtask

  task automatic test_random_reads();
    for (int t = 0; t < 2; t++) begin
      logic [23:0] a;
      int nw;
      a = 24'($urandom);
      nw = $urandom_range(2, 3);
      ack_delay = $urandom_range(1, 6);
      do_read(a, nw);
      check_reads("random_read", a, nw, 1'b0);
    end
    ack_delay = 2;
  endtask

  task automatic test_timeout();
    logic [23:0] a;
    a = 24'($urandom);
    ack_en = 1'b0;
    do_read(a, 1);
    ack_en = 1'b1;
    check_reads("timeout", a, 1, 1'b1);
    checks++;
    if (err_pulses != 3) begin
      errors++;
      $display("FAIL timeout err: got %0d pulses expected 3", err_pulses);
    end
    foreach (len_q[i]) begin
      checks++;
      if (len_q[i] != 16) begin
        errors++;
        $display("FAIL timeout len%0d: got %0d clk expected 16", i, len_q[i]);
      end
    end
  endtask

  task automatic test_abort_badcmd();
    logic [7:0] r;
    clear_log();
    spi_start();
    send_hdr(8'h02, 24'($urandom));
    spi_byte(8'($urandom), r);
    spi_byte(8'($urandom), r);
    spi_stop();
    wait_idle("abort");
    checks++;
    if (log_q.size() != 0) begin
      errors++;
      $display("FAIL abort cycles: got %0d expected 0", log_q.size());
    end
    clear_log();
    spi_start();
    spi_byte(8'h9F, r);
    for (int k = 0; k < 4; k++) spi_byte(8'($urandom), r);
    spi_stop();
    wait_idle("badcmd");
    checks++;
    if (log_q.size() != 0 || oe_seen !== 1'b0) begin
      errors++;
      $display("FAIL badcmd: got cycles=%0d oe_seen=%b expected 0 0",
               log_q.size(), oe_seen);
    end
    wq.delete();
    wq.push_back($urandom);
    do_write(24'h000100, 0);
    check_writes("after_abort", 24'h000100);
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int n;
    ack_en = 1'b0;
    clear_log();
    spi_start();
    send_hdr(8'h02, 24'h000040);
    for (int b = 0; b < 4; b++) spi_byte(8'($urandom), r);
    n = 0;
    while (!stb_o && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (stb_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid stb: got %b expected 1", stb_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
         miso_o, miso_oe_o, busy_o, err_o} !== 75'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got cyc=%b stb=%b adr=%h dat=%h busy=%b expected all 0",
               cyc_o, stb_o, adr_o, dat_o, busy_o);
    end
    csb = 1'b1;
    tick(4);
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick(6);
    wq.delete();
    wq.push_back($urandom);
    do_write(24'h000080, 0);
    check_writes("after_reset", 24'h000080);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_random_writes();
    test_read_prefetch();
    test_random_reads();
    test_timeout();
    test_abort_badcmd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
